// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It issues word-address requests to instruction
// memory, drops responses that a redirect has made stale, and fills the F/D
// pipeline latch. A one-entry skid buffer holds a response that arrives while
// decode is stalled.
//
// Ports
//   clock          in   1   sole clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   imem_req       out  1   instruction-memory request
//   imem_addr      out  32  word address of the request (always PC)
//   imem_ready     in   1   imem_data valid; completes the outstanding request
//   imem_data      in   32  returned instruction word
//   branch         in   1   redirect from execute-stage PC control
//   branch_target  in   32  redirect address, used only when branch=1
//   stall          in   1   hazard unit holds the F/D latch
//   pc_plus_one    out  32  combinational PC+1
//   fd_pc          out  32  F/D latch: PC of held instruction
//   fd_pc_plus_one out  32  F/D latch: fd_pc+1
//   fd_insn        out  32  F/D latch: instruction word
//   fd_valid       out  1   F/D latch holds a real instruction (0 = bubble)
//
// Handshake: a request is outstanding whenever imem_req=1. The memory
// completes it by raising imem_ready for one cycle with imem_data valid; the
// address does not change until that happens. In HOLD no request is issued
// and imem_ready is ignored.
// ---------------------------------------------------------------------------
module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] pc_plus_one,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc_plus_one,
    output logic [31:0] fd_insn,
    output logic        fd_valid
);

    // FETCH   : request outstanding, response is usable
    // DISCARD : request outstanding, response is stale (redirect pending)
    // HOLD    : response parked in the skid buffer while decode stalls
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic [31:0] fd_pc1_q, fd_pc1_d;
    logic [31:0] fd_insn_q, fd_insn_d;
    logic        fd_valid_q, fd_valid_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= 32'd0;
            redir_q    <= 32'd0;
            skid_q     <= 32'd0;
            fd_pc_q    <= 32'd0;
            fd_pc1_q   <= 32'd0;
            fd_insn_q  <= 32'd0;
            fd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_q    <= redir_d;
            skid_q     <= skid_d;
            fd_pc_q    <= fd_pc_d;
            fd_pc1_q   <= fd_pc1_d;
            fd_insn_q  <= fd_insn_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    // 32-bit add wraps naturally from 0xFFFFFFFF to 0.
    assign pc_plus_one = pc_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        skid_d     = skid_q;
        fd_pc_d    = fd_pc_q;
        fd_pc1_d   = fd_pc1_q;
        fd_insn_d  = fd_insn_q;
        fd_valid_d = fd_valid_q;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (branch) begin
                        // Response belongs to the wrong path: drop it.
                        pc_d       = branch_target;
                        fd_valid_d = 1'b0;
                    end else if (!stall) begin
                        fd_pc_d    = pc_q;
                        fd_pc1_d   = pc_plus_one;
                        fd_insn_d  = imem_data;
                        fd_valid_d = 1'b1;
                        pc_d       = pc_plus_one;
                    end else begin
                        // Decode is busy; park the word and stop fetching.
                        skid_d  = imem_data;
                        state_d = S_HOLD;
                    end
                end else begin
                    if (branch) begin
                        // The address is already on the bus and cannot be
                        // withdrawn; remember the target and drop the reply.
                        redir_d    = branch_target;
                        fd_valid_d = 1'b0;
                        state_d    = S_DISCARD;
                    end else if (!stall) begin
                        fd_valid_d = 1'b0;
                    end
                end
            end

            S_DISCARD: begin
                fd_valid_d = 1'b0;
                if (branch) begin
                    redir_d = branch_target;
                end
                if (imem_ready) begin
                    pc_d    = branch ? branch_target : redir_q;
                    state_d = S_FETCH;
                end
            end

            S_HOLD: begin
                if (branch) begin
                    pc_d       = branch_target;
                    fd_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    fd_pc_d    = pc_q;
                    fd_pc1_d   = pc_plus_one;
                    fd_insn_d  = skid_q;
                    fd_valid_d = 1'b1;
                    pc_d       = pc_plus_one;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Request is suppressed while reset is held so nothing is issued early.
    assign imem_req       = reset && (state_q != S_HOLD);
    assign imem_addr      = pc_q;
    assign fd_pc          = fd_pc_q;
    assign fd_pc_plus_one = fd_pc1_q;
    assign fd_insn        = fd_insn_q;
    assign fd_valid       = fd_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. A behavioural model tracks the fetch stream in
// terms of "outstanding redirect" and "parked word" and is compared against
// the DUT outputs every cycle. Directed sequences with literal expectations
// cover the reference scenarios, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] pc_plus_one;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus_one;
    logic [31:0] fd_insn;
    logic        fd_valid;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .branch         (branch),
        .branch_target  (branch_target),
        .stall          (stall),
        .pc_plus_one    (pc_plus_one),
        .fd_pc          (fd_pc),
        .fd_pc_plus_one (fd_pc_plus_one),
        .fd_insn        (fd_insn),
        .fd_valid       (fd_valid)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_redirect_pending: an address is on the bus whose reply must be thrown
    //                     away; m_redirect_to is where fetch resumes.
    // m_parked:           a fetched word waits for decode to accept it.
    logic [31:0] m_pc          = 32'd0;
    logic [31:0] m_redirect_to = 32'd0;
    logic [31:0] m_parked_word = 32'd0;
    bit          m_redirect_pending = 1'b0;
    bit          m_parked = 1'b0;
    logic [31:0] m_fd_pc   = 32'd0;
    logic [31:0] m_fd_insn = 32'd0;
    bit          m_fd_valid = 1'b0;

    task automatic deliver(input logic [31:0] word);
        m_fd_pc    = m_pc;
        m_fd_insn  = word;
        m_fd_valid = 1'b1;
        m_pc       = m_pc + 32'd1;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = 32'd0;
            m_redirect_to = 32'd0;
            m_parked_word = 32'd0;
            m_redirect_pending = 1'b0;
            m_parked = 1'b0;
            m_fd_pc = 32'd0;
            m_fd_insn = 32'd0;
            m_fd_valid = 1'b0;
        end else if (m_parked) begin
            if (branch) begin
                m_parked = 1'b0;
                m_pc = branch_target;
                m_fd_valid = 1'b0;
            end else if (!stall) begin
                m_parked = 1'b0;
                deliver(m_parked_word);
            end
        end else if (m_redirect_pending) begin
            m_fd_valid = 1'b0;
            if (branch) m_redirect_to = branch_target;
            if (imem_ready) begin
                m_pc = m_redirect_to;
                m_redirect_pending = 1'b0;
            end
        end else if (imem_ready) begin
            if (branch) begin
                m_pc = branch_target;
                m_fd_valid = 1'b0;
            end else if (!stall) begin
                deliver(imem_data);
            end else begin
                m_parked = 1'b1;
                m_parked_word = imem_data;
            end
        end else begin
            if (branch) begin
                m_redirect_pending = 1'b1;
                m_redirect_to = branch_target;
                m_fd_valid = 1'b0;
            end else if (!stall) begin
                m_fd_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, reset & ~m_parked});
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_plus_one", pc_plus_one, m_pc + 32'd1);
            chk("fd_valid", {31'd0, fd_valid}, {31'd0, m_fd_valid});
            if (m_fd_valid) begin
                chk("fd_pc", fd_pc, m_fd_pc);
                chk("fd_pc_plus_one", fd_pc_plus_one, m_fd_pc + 32'd1);
                chk("fd_insn", fd_insn, m_fd_insn);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; applies inputs, optionally moves reset a bit
    // later in the low phase, and returns at the next falling edge.
    task automatic step(input bit rdy, input bit br, input logic [31:0] tgt,
                        input bit st, input logic [31:0] data, input bit rst_v);
        imem_ready    = rdy;
        branch        = br;
        branch_target = tgt;
        stall         = st;
        imem_data     = data;
        if (rst_v != reset) begin
            #2 reset = rst_v;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Directed step: memory returns address + 0x100.
    task automatic dstep(input bit rdy, input bit br, input logic [31:0] tgt, input bit st);
        step(rdy, br, tgt, st, m_pc + 32'h100, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        // reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_fd_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst_fd_pc", fd_pc, 32'd0);
        chk("rst_fd_insn", fd_insn, 32'd0);
        chk("rst_fd_pc1", fd_pc_plus_one, 32'd0);

        // release reset with no response: bubble, request address 0
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'h100, 1'b1);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);

        // zero-wait stream
        for (int i = 0; i < 5; i++) begin
            dstep(1'b1, 1'b0, 32'd0, 1'b0);
            chk("zw_valid", {31'd0, fd_valid}, 32'd1);
            chk("zw_fd_pc", fd_pc, i);
            chk("zw_fd_insn", fd_insn, 32'h100 + i);
        end
        chk("zw_fd_pc1", fd_pc_plus_one, 32'd5);
        chk("model_pc5", m_pc, 32'd5);

        // stall during a ready cycle at PC=5
        dstep(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("st_req", {31'd0, imem_req}, 32'd0);
            chk("st_fd_pc", fd_pc, 32'd4);
            chk("st_fd_insn", fd_insn, 32'h104);
            dstep(1'b1, 1'b0, 32'd0, 1'b1);
        end
        chk("st_req3", {31'd0, imem_req}, 32'd0);
        dstep(1'b0, 1'b0, 32'd0, 1'b0);
        chk("unst_fd_pc", fd_pc, 32'd5);
        chk("unst_fd_insn", fd_insn, 32'h105);
        chk("unst_addr", imem_addr, 32'd6);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("unst_next", fd_pc, 32'd6);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("pc8_addr", imem_addr, 32'd8);

        // branch while waiting at PC=8
        dstep(1'b0, 1'b1, 32'h40, 1'b0);
        chk("bw_valid0", {31'd0, fd_valid}, 32'd0);
        chk("bw_addr0", imem_addr, 32'd8);
        dstep(1'b0, 1'b0, 32'd0, 1'b0);
        chk("bw_valid1", {31'd0, fd_valid}, 32'd0);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("bw_valid2", {31'd0, fd_valid}, 32'd0);
        chk("bw_addr", imem_addr, 32'h40);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("bw_fd_pc", fd_pc, 32'h40);
        chk("bw_fd_insn", fd_insn, 32'h140);

        // branch plus stall in HOLD
        dstep(1'b1, 1'b0, 32'd0, 1'b1);
        chk("bh_req", {31'd0, imem_req}, 32'd0);
        dstep(1'b0, 1'b1, 32'h80, 1'b1);
        chk("bh_valid", {31'd0, fd_valid}, 32'd0);
        chk("bh_addr", imem_addr, 32'h80);
        chk("model_pc80", m_pc, 32'h80);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("bh_fd_pc", fd_pc, 32'h80);
        chk("bh_fd_insn", fd_insn, 32'h180);

        // wrap
        dstep(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFF);
        chk("wr_pc1", pc_plus_one, 32'd0);
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        chk("wr_fd_pc", fd_pc, 32'hFFFF_FFFF);
        chk("wr_fd_pc1", fd_pc_plus_one, 32'd0);
        chk("wr_fd_insn", fd_insn, 32'h0000_00FF);
        chk("wr_addr0", imem_addr, 32'd0);

        // reset pulsed mid-DISCARD
        dstep(1'b1, 1'b0, 32'd0, 1'b0);
        dstep(1'b0, 1'b1, 32'h20, 1'b0);
        chk("rd_addr", imem_addr, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rd_async_addr", imem_addr, 32'd0);
        chk("rd_async_valid", {31'd0, fd_valid}, 32'd0);
        chk("rd_async_req", {31'd0, imem_req}, 32'd0);
        chk("rd_async_fd_pc", fd_pc, 32'd0);
        @(negedge clock);
        // ready in first cycle after release is accepted for address 0
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'h100, 1'b1);
        chk("rd_fd_valid", {31'd0, fd_valid}, 32'd1);
        chk("rd_fd_pc", fd_pc, 32'd0);
        chk("rd_fd_insn", fd_insn, 32'h100);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            bit          rst_v;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom;
            rst_v = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 12, tgt,
                 $urandom_range(0, 99) < 30, $urandom, rst_v);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address of the request; equals PC.
- imem_ready  in  1  imem_data valid this cycle; completes the outstanding request.
- imem_data  in  32  returned instruction word.
- branch  in  1  redirect from the execute-stage PC control.
- branch_target  in  32  redirect address; sampled only when branch=1.
- stall  in  1  hazard unit holds the F/D latch.
- pc_plus_one  out  32  combinational PC+1, fed to the execute-stage PC control.
- fd_pc  out  32  F/D latch: PC of the held instruction.
- fd_pc_plus_one  out  32  F/D latch: fd_pc+1.
- fd_insn  out  32  F/D latch: instruction word.
- fd_valid  out  1  F/D latch holds a real instruction; 0 means bubble.

Function
REQ-002 State machine states SHALL be FETCH, DISCARD and HOLD, plus a 32-bit PC, a 32-bit redirect register and a 32-bit skid buffer.
REQ-003 imem_req SHALL be 1 in FETCH and DISCARD, and 0 in HOLD; imem_addr SHALL equal PC at all times.
REQ-004 PC arithmetic SHALL be 32-bit modulo: PC 0xFFFFFFFF increments to 0x00000000; pc_plus_one wraps the same way.
REQ-005 In FETCH with imem_ready=1 and branch=1: PC SHALL load branch_target, fd_valid SHALL become 0, imem_data SHALL be dropped, and the state SHALL stay FETCH.
REQ-006 In FETCH with imem_ready=1, branch=0 and stall=0: the F/D latch SHALL load {PC, PC+1, imem_data, valid=1}, PC SHALL load PC+1, and the state SHALL stay FETCH; latency from address issue to F/D is 1 edge after ready.
REQ-007 In FETCH with imem_ready=1, branch=0 and stall=1: the F/D latch SHALL hold, imem_data SHALL be captured in the skid buffer, and the state SHALL go to HOLD; PC SHALL be unchanged.
REQ-008 In FETCH with imem_ready=0 and branch=1: the redirect register SHALL load branch_target, fd_valid SHALL become 0, and the state SHALL go to DISCARD.
REQ-009 In FETCH with imem_ready=0 and branch=0: if stall=0, fd_valid SHALL become 0 (bubble); if stall=1, the F/D latch SHALL hold.
REQ-010 In DISCARD:
- PC and imem_addr SHALL stay at the old address until imem_ready.
- branch=1 SHALL overwrite the redirect register (the newest target wins).
- fd_valid SHALL be 0.
- On imem_ready, the response SHALL be dropped, PC SHALL load the redirect register (or branch_target if branch=1 in that same cycle), and the state SHALL go to FETCH.
REQ-011 In HOLD with branch=1: the skid buffer SHALL be discarded, PC SHALL load branch_target, fd_valid SHALL become 0, and the state SHALL go to FETCH.
REQ-012 In HOLD with branch=0 and stall=0: the F/D latch SHALL load {PC, PC+1, skid, valid=1}, PC SHALL load PC+1, and the state SHALL go to FETCH.
REQ-013 In HOLD with branch=0 and stall=1: all state SHALL hold.
REQ-014 branch SHALL take priority over stall in every state; a flush clears fd_valid even while stall=1.
REQ-015 fd_pc, fd_pc_plus_one and fd_insn SHALL be don't-care when fd_valid=0, but SHALL hold their last values.

Reset
REQ-016 reset=0 SHALL immediately and asynchronously force:
- PC=0, state=FETCH;
- fd_valid=0; fd_pc, fd_pc_plus_one and fd_insn=0;
- redirect register and skid buffer=0.
REQ-017 While reset=0, imem_req SHALL be 0; on the first rising edge after reset deasserts, the block SHALL request address 0.
REQ-018 Reset asserted mid-request SHALL abandon the request; any imem_ready seen in the first cycle after release SHALL be ignored only if the state is DISCARD, otherwise it SHALL be accepted for address 0.

Verification
REQ-019 Zero-wait stream: imem_ready=1 every cycle, data=addr+0x100 -> fd_pc goes 0,1,2,3, fd_insn goes 0x100 to 0x103, fd_valid=1 from the 2nd edge.
REQ-020 Stall during a ready cycle: at PC=5, stall=1 for 3 cycles -> F/D holds insn 4, state HOLD, imem_req=0; after stall drops, fd_pc=5 and fd_insn=0x105 with no instruction lost or duplicated.
REQ-021 Branch while waiting: at PC=8 with imem_ready=0, branch=1 and target=0x40; ready arrives 2 cycles later -> data for 8 is dropped, next imem_addr=0x40, and fd_valid=0 throughout.
REQ-022 Branch plus stall in the same cycle while in HOLD -> fd_valid=0, PC=target, and the skid buffer is never delivered.
REQ-023 Wrap: PC=0xFFFFFFFF with ready -> fd_pc_plus_one=0 and next PC=0; and reset pulsed low mid-DISCARD -> PC=0, fd_valid=0 with no clock edge.
